mm_burst_dmem: RTL and testbench
================================

# mm_burst_dmem

Data memory sitting directly downstream of the CPU data port and the matrix-multiply accelerator's wide port. It serves 32-bit byte-enabled CPU loads and stores combinationally and serialises 256-bit accelerator reads and writes into 8 word beats over a single word-wide write port. The CPU port has priority, so a CPU store stalls the active burst for that cycle.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; a power of two.
- `AW`, default $clog2(DEPTH_WORDS): word-index width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `daddr` in 32: CPU byte address. Word index is `daddr[AW+1:2]`; upper bits are ignored, so addresses wrap.
- `dwdata` in 32: CPU store data, already lane-replicated.
- `dwe` in 4: CPU byte write enables.
- `drdata` out 32: CPU read word, combinational from `daddr`.
- `mm_req` in 1: wide-access request, sampled only in IDLE.
- `mm_we` in 1: 1 selects a 256-bit write, 0 selects a 256-bit read.
- `mm_addr` in 32: wide byte address. Bits [4:0] are ignored (32-byte aligned).
- `mm_wdata` in 256: wide write data; word k is bits [32k+31:32k].
- `mm_rdata` out 256: assembled read data, registered.
- `mm_busy` out 1: burst in progress.
- `mm_done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE and BURST.
  - IDLE → BURST on `mm_req`.
  - BURST → IDLE after beat 7 completes.
- Acceptance edge (IDLE with `mm_req`) latches:
  - base word = `mm_addr[AW+1:5]` concatenated with 3'b000
  - `mm_we`
  - `mm_wdata`
  - beat counter = 0
- Each BURST cycle without a CPU store (`dwe==0`) processes beat k at word (base+k) mod DEPTH_WORDS:
  - Write: `mem <= wdata_lat[32k+31:32k]`.
  - Read: `rdata_reg[32k+31:32k] <= mem`.
  - Then k increments.
- A BURST cycle with `dwe!=0` performs the CPU store only; the beat does not advance and no burst read/write occurs.
- CPU store writes byte lane i when `dwe[i]`, in every state.
- `drdata` always equals the current `mem` contents at the `daddr` word. It is not gated by state.
- If a CPU store and a later burst beat target the same word, the burst beat overwrites it, since that beat executes after the stall.
- `mm_req` while busy is ignored; there is no queue.
- `mm_rdata` holds its last value until the next read burst overwrites beats. Write bursts leave it unchanged.
- Reset mid-burst: returns to IDLE, drops the burst, and leaves already-written words in memory. Memory contents are never cleared by reset.

## Timing
- Reset values:
  - `mm_busy` = 0, `mm_done` = 0, `mm_rdata` = 0, state = IDLE, beat = 0.
  - `drdata` reflects memory contents (uninitialised memory unless preloaded).
- Acceptance at edge E0; `mm_busy` goes high after E0.
- Beats occur on edges E1..E8 when there are no stalls. Each CPU-store cycle adds one edge.
- After the edge completing beat 7:
  - `mm_busy` = 0 and `mm_done` = 1 for exactly one cycle.
  - `mm_rdata` is complete and stable for a read burst.
- A new `mm_req` may be accepted in the `mm_done` cycle, since the FSM is already in IDLE. That gives back-to-back bursts with a 9-edge period.
- CPU store latency: written at the edge where `dwe` is asserted; visible on `drdata` the next cycle.

## Structure
- Package `mm_mem_pkg`:
  - `MM_BEATS` = 8
  - `MM_WIDE_W` = 256
  - state enum {IDLE, BURST}
  - beat-index typedef (3 bits)
- Sub-module `dmem_array`:
  - `DEPTH_WORDS` × 32 storage
  - one write port with 4-bit byte enables
  - two asynchronous read ports (CPU word, burst word)
- `mm_burst_dmem` contains the FSM, the write-port arbiter (CPU priority), the beat counter, the address adder with wrap, and the `mm_rdata` assembly.

## Test plan
- **Wide write/read:** `mm_req`, `mm_we`=1, `mm_addr`=0x40, `mm_wdata` words = 0x11111111×(k+1).
  - After 9 edges `mm_done` pulses and `mm_busy` falls.
  - CPU `daddr`=0x4C reads 0x44444444.
  - A read burst at 0x40 returns identical 256 bits.
- **CPU stall:** during a write burst, assert `dwe`=4'hF, `daddr`=0x48, `dwdata`=0xDEADBEEF on the beat-2 cycle.
  - Done arrives at edge 10.
  - Word 0x48 ends as the burst value 0x33333333.
- **Byte store:** `dwe`=4'b0100, `daddr`=0x102, `dwdata`=0xAAAAAAAA onto a word holding 0.
  - `drdata` at 0x100 = 0x00AA0000.
- **Wrap and alignment:** `DEPTH_WORDS`=16, `mm_addr`=0x3F (behaves as 0x20) with writes.
  - Words 8..15 are written; words 0..7 are untouched.
- **Ignored request and reset:** `mm_req` pulsed mid-burst has no effect.
  - `reset` after beat 3 → `mm_busy`=0, `mm_done`=0, `mm_rdata`=0.
  - Words 0..2 of that burst are written; words 3..7 keep their old data.
- **Back-to-back:** hold `mm_req` high across the `mm_done` cycle.
  - Second burst is accepted on that edge.
  - Two done pulses 9 edges apart.

Source files
------------

// File: rtl/mm_mem_pkg.sv
// Shared types and constants for the CPU/accelerator data memory.
// A wide access is MM_BEATS consecutive 32-bit words.
package mm_mem_pkg;

    localparam int MM_BEATS  = 8;
    localparam int MM_WIDE_W = 256;
    localparam int MM_WORD_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } mm_state_t;

    typedef logic [2:0] beat_idx_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: one byte-enabled write port, two asynchronous read ports.
// The CPU and the burst engine read independently; the top arbitrates the write port.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    wbe,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] cpu_raddr,
    output logic [31:0]   cpu_rdata,
    input  logic [AW-1:0] burst_raddr,
    output logic [31:0]   burst_rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the storage array has no reset on purpose; clearing it would force a
    // flop-based memory instead of a RAM, and contents must survive reset anyway.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign cpu_rdata   = mem[cpu_raddr];
    assign burst_rdata = mem[burst_raddr];

endmodule

// File: rtl/mm_burst_dmem.sv
// Data memory shared by the CPU port (combinational, priority) and the
// accelerator's 256-bit port, which is serialised into 8 word beats.
module mm_burst_dmem
    import mm_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          daddr,
    input  logic [31:0]          dwdata,
    input  logic [3:0]           dwe,
    output logic [31:0]          drdata,
    input  logic                 mm_req,
    input  logic                 mm_we,
    input  logic [31:0]          mm_addr,
    input  logic [MM_WIDE_W-1:0] mm_wdata,
    output logic [MM_WIDE_W-1:0] mm_rdata,
    output logic                 mm_busy,
    output logic                 mm_done
);

    mm_state_t            state, state_next;
    beat_idx_t            beat, beat_next;
    logic [AW-1:0]        base_word, burst_word, cpu_word;
    logic                 we_lat;
    logic [MM_WIDE_W-1:0] wdata_lat, rdata_reg;
    logic                 done, done_next;
    logic                 cpu_store, beat_fire, accept;
    logic [3:0]           wr_be;
    logic [AW-1:0]        wr_addr;
    logic [31:0]          wr_data, burst_rdata;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{daddr[31:AW+2], daddr[1:0], mm_addr[31:AW+2], mm_addr[4:0]};

    assign cpu_store  = |dwe;
    assign cpu_word   = daddr[AW+1:2];
    assign burst_word = base_word + AW'(beat);

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        done_next  = 1'b0;
        accept     = 1'b0;
        beat_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (mm_req) begin
                    accept     = 1'b1;
                    state_next = BURST;
                    beat_next  = '0;
                end
            end
            BURST: begin
                // A CPU store owns the write port this cycle; the beat waits.
                // Reset also suppresses the beat so a dropped burst writes nothing more.
                if (!cpu_store && !reset) begin
                    beat_fire = 1'b1;
                    beat_next = beat + 1'b1;
                    if (beat == beat_idx_t'(MM_BEATS - 1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_be   = '0;
        wr_addr = cpu_word;
        wr_data = dwdata;
        if (cpu_store) begin
            wr_be = dwe;
        end else if (beat_fire && we_lat) begin
            wr_be   = 4'hF;
            wr_addr = burst_word;
            wr_data = wdata_lat[beat*MM_WORD_W +: MM_WORD_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            done      <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
            done  <= done_next;
            if (beat_fire && !we_lat) rdata_reg[beat*MM_WORD_W +: MM_WORD_W] <= burst_rdata;
        end
    end

    // Request capture only matters once accepted, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            base_word <= {mm_addr[AW+1:5], 3'b000};
            we_lat    <= mm_we;
            wdata_lat <= mm_wdata;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk        (clk),
        .wbe        (wr_be),
        .waddr      (wr_addr),
        .wdata      (wr_data),
        .cpu_raddr  (cpu_word),
        .cpu_rdata  (drdata),
        .burst_raddr(burst_word),
        .burst_rdata(burst_rdata)
    );

    assign mm_busy  = (state == BURST);
    assign mm_done  = done;
    assign mm_rdata = rdata_reg;

endmodule

// File: tb/tb_mm_burst_dmem.sv
// Self-checking bench for mm_burst_dmem: directed scenarios plus randomized
// bursts checked against a word-level memory model kept in the bench.
module tb_mm_burst_dmem;

    localparam int DEPTH  = 1024;
    localparam int SDEPTH = 16;

    logic         clk, reset;
    logic [31:0]  daddr, dwdata, drdata;
    logic [3:0]   dwe;
    logic         mm_req, mm_we, mm_busy, mm_done;
    logic [31:0]  mm_addr;
    logic [255:0] mm_wdata, mm_rdata;

    logic [31:0]  s_daddr, s_dwdata, s_drdata;
    logic [3:0]   s_dwe;
    logic         s_mm_req, s_mm_we, s_mm_busy, s_mm_done;
    logic [31:0]  s_mm_addr;
    logic [255:0] s_mm_wdata, s_mm_rdata;

    int checks = 0;
    int fails  = 0;

    logic [31:0]  model_mem [int];
    logic [255:0] model_rdata;

    mm_burst_dmem #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata),
        .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
        .mm_rdata(mm_rdata), .mm_busy(mm_busy), .mm_done(mm_done)
    );

    mm_burst_dmem #(.DEPTH_WORDS(SDEPTH)) dut_small (
        .clk(clk), .reset(reset), .daddr(s_daddr), .dwdata(s_dwdata), .dwe(s_dwe), .drdata(s_drdata),
        .mm_req(s_mm_req), .mm_we(s_mm_we), .mm_addr(s_mm_addr), .mm_wdata(s_mm_wdata),
        .mm_rdata(s_mm_rdata), .mm_busy(s_mm_busy), .mm_done(s_mm_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic int burst_base(input logic [31:0] a);
        return int'(((a >> 5) * 8) % DEPTH);
    endfunction

    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] v;
        int w;
        w = word_of(a);
        v = model_mem.exists(w) ? model_mem[w] : 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
        model_mem[w] = v;
        daddr = a; dwdata = d; dwe = be;
        tick();
        dwe = 4'h0;
    endtask

    // Runs one wide access, optionally stalling it with a CPU store before beat
    // stall_beat and pulsing a stray mm_req on loop cycle poke_cyc. Edges are
    // counted from the acceptance edge (which counts as 1).
    task automatic do_burst(input logic we, input logic [31:0] addr, input logic [255:0] wd,
                            input int stall_beat, input logic [31:0] st_addr, input logic [31:0] st_data,
                            input int poke_cyc, input logic [31:0] poke_addr,
                            output int done_at, output logic busy_at);
        int bk, base, edges, cyc, w;
        bit stalled;
        base = burst_base(addr);
        dwe = 4'h0;
        mm_req = 1'b1; mm_we = we; mm_addr = addr; mm_wdata = wd;
        tick();
        edges = 1;
        mm_req = 1'b0; mm_we = ~we; mm_addr = ~addr; mm_wdata = ~wd;
        bk = 0; stalled = 1'b0; cyc = 0; done_at = -1; busy_at = 1'bx;
        while (bk < 8 && edges < 40) begin
            if (cyc == poke_cyc) begin
                mm_req = 1'b1; mm_we = 1'b1; mm_addr = poke_addr;
            end else begin
                mm_req = 1'b0;
            end
            if (bk == stall_beat && !stalled) begin
                daddr = st_addr; dwdata = st_data; dwe = 4'hF;
                model_mem[word_of(st_addr)] = st_data;
                stalled = 1'b1;
            end else begin
                dwe = 4'h0;
                w = (base + bk) % DEPTH;
                if (we) model_mem[w] = wd[32*bk +: 32];
                else    model_rdata[32*bk +: 32] = model_mem[w];
                bk++;
            end
            tick();
            edges++; cyc++;
            if (mm_done === 1'b1 && done_at < 0) begin done_at = edges; busy_at = mm_busy; end
        end
        mm_req = 1'b0; dwe = 4'h0;
        while (done_at < 0 && edges < 40) begin
            tick();
            edges++;
            if (mm_done === 1'b1) begin done_at = edges; busy_at = mm_busy; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (mm_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", mm_busy); end
        checks++; if (mm_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", mm_done); end
        checks++; if (mm_rdata !== 256'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", mm_rdata); end
        checks++; if (s_mm_busy !== 1'b0) begin fails++; $display("FAIL reset_small_busy: got %b want 0", s_mm_busy); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_wide_write_read();
        logic [255:0] wd;
        int done_at;
        logic busy_at;
        for (int k = 0; k < 8; k++) wd[32*k +: 32] = 32'h1111_1111 * (k + 1);
        do_burst(1'b1, 32'h40, wd, -1, 32'h0, 32'h0, -1, 32'h0, done_at, busy_at);
        checks++; if (done_at != 9) begin fails++; $display("FAIL wr_done_edge: got %0d want 9", done_at); end
        checks++; if (busy_at !== 1'b0) begin fails++; $display("FAIL wr_busy_at_done: got %b want 0", busy_at); end
        tick();
        checks++; if (mm_done !== 1'b0) begin fails++; $display("FAIL wr_done_one_cycle: got %b want 0", mm_done); end
        daddr = 32'h4C; #1;
        checks++; if (drdata !== 32'h4444_4444) begin fails++; $display("FAIL wr_cpu_read_4c: got %h want 44444444", drdata); end
        do_burst(1'b0, 32'h40, 256'h0, -1, 32'h0, 32'h0, -1, 32'h0, done_at, busy_at);
        checks++; if (done_at != 9) begin fails++; $display("FAIL rd_done_edge: got %0d want 9", done_at); end
        checks++; if (mm_rdata !== wd) begin fails++; $display("FAIL rd_data: got %h want %h", mm_rdata, wd); end
    endtask

    task automatic test_cpu_stall();
        logic [255:0] wd;
        int done_at;
        logic busy_at;
        for (int k = 0; k < 8; k++) wd[32*k +: 32] = 32'h1111_1111 * (k + 1);
        do_burst(1'b1, 32'h40, wd, 2, 32'h48, 32'hDEAD_BEEF, -1, 32'h0, done_at, busy_at);
        checks++; if (done_at != 10) begin fails++; $display("FAIL stall_done_edge: got %0d want 10", done_at); end
        daddr = 32'h48; #1;
        checks++; if (drdata !== 32'h3333_3333) begin fails++; $display("FAIL stall_word_48: got %h want 33333333", drdata); end
    endtask

    task automatic test_byte_store();
        cpu_store(32'h100, 32'h0, 4'hF);
        cpu_store(32'h102, 32'hAAAA_AAAA, 4'b0100);
        daddr = 32'h100; #1;
        checks++; if (drdata !== 32'h00AA_0000) begin fails++; $display("FAIL byte_store: got %h want 00aa0000", drdata); end
    endtask

    task automatic test_wrap();
        logic [255:0] swd;
        logic [31:0]  exp_w;
        int edges, base, off;
        bit seen;
        for (int w = 0; w < SDEPTH; w++) begin
            s_daddr = 32'(w * 4); s_dwdata = 32'hC0DE_0000 | 32'(w); s_dwe = 4'hF;
            tick();
        end
        s_dwe = 4'h0;
        for (int k = 0; k < 8; k++) swd[32*k +: 32] = $urandom;
        s_mm_req = 1'b1; s_mm_we = 1'b1; s_mm_addr = 32'h3F; s_mm_wdata = swd;
        tick();
        s_mm_req = 1'b0; s_mm_wdata = ~swd;
        edges = 1; seen = 1'b0;
        while (!seen && edges < 40) begin
            tick();
            edges++;
            if (s_mm_done === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || edges != 9) begin fails++; $display("FAIL wrap_done_edge: got %0d want 9", edges); end
        base = ((32'h3F >> 5) * 8) % SDEPTH;
        for (int w = 0; w < SDEPTH; w++) begin
            off   = (w - base + SDEPTH) % SDEPTH;
            exp_w = (off < 8) ? swd[32*off +: 32] : (32'hC0DE_0000 | 32'(w));
            s_daddr = 32'(w * 4); #1;
            checks++; if (s_drdata !== exp_w) begin fails++; $display("FAIL wrap_word_%0d: got %h want %h", w, s_drdata, exp_w); end
        end
    endtask

    task automatic test_ignored_req_and_reset();
        logic [255:0] wd_old, wd_other, wd_new, wd3;
        int done_at, w;
        logic busy_at;
        for (int k = 0; k < 8; k++) begin
            wd_old[32*k +: 32] = $urandom; wd_other[32*k +: 32] = $urandom;
            wd_new[32*k +: 32] = $urandom; wd3[32*k +: 32] = $urandom;
        end
        do_burst(1'b1, 32'h200, wd_old, -1, 32'h0, 32'h0, -1, 32'h0, done_at, busy_at);
        do_burst(1'b1, 32'h300, wd_other, -1, 32'h0, 32'h0, -1, 32'h0, done_at, busy_at);
        do_burst(1'b1, 32'h200, wd_new, -1, 32'h0, 32'h0, 3, 32'h300, done_at, busy_at);
        checks++; if (done_at != 9) begin fails++; $display("FAIL ign_done_edge: got %0d want 9", done_at); end
        repeat (2) tick();
        checks++; if (mm_busy !== 1'b0) begin fails++; $display("FAIL ign_no_queue: busy got %b want 0", mm_busy); end
        for (int k = 0; k < 8; k++) begin
            w = word_of(32'h300) + k;
            daddr = 32'(w * 4); #1;
            checks++; if (drdata !== model_mem[w]) begin fails++; $display("FAIL ign_region_%0d: got %h want %h", k, drdata, model_mem[w]); end
        end
        // Abort a write burst once three beats have landed.
        mm_req = 1'b1; mm_we = 1'b1; mm_addr = 32'h200; mm_wdata = wd3;
        tick();
        mm_req = 1'b0; mm_wdata = ~wd3;
        for (int k = 0; k < 3; k++) begin
            model_mem[word_of(32'h200) + k] = wd3[32*k +: 32];
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_rdata = 256'h0;
        checks++; if (mm_busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", mm_busy); end
        checks++; if (mm_done !== 1'b0) begin fails++; $display("FAIL rst_mid_done: got %b want 0", mm_done); end
        checks++; if (mm_rdata !== model_rdata) begin fails++; $display("FAIL rst_mid_rdata: got %h want 0", mm_rdata); end
        repeat (3) tick();
        checks++; if (mm_busy !== 1'b0 || mm_done !== 1'b0) begin fails++; $display("FAIL rst_stays_idle: busy %b done %b want 0 0", mm_busy, mm_done); end
        for (int k = 0; k < 8; k++) begin
            w = word_of(32'h200) + k;
            daddr = 32'(w * 4); #1;
            checks++; if (drdata !== model_mem[w]) begin fails++; $display("FAIL rst_word_%0d: got %h want %h", k, drdata, model_mem[w]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] wa, wb;
        int done_edges [2];
        int nd, edges, w;
        bit drop;
        for (int k = 0; k < 8; k++) begin wa[32*k +: 32] = $urandom; wb[32*k +: 32] = $urandom; end
        done_edges[0] = -1; done_edges[1] = -1;
        nd = 0; drop = 1'b0;
        mm_req = 1'b1; mm_we = 1'b1; mm_addr = 32'h400; mm_wdata = wa;
        tick();
        edges = 1;
        while (nd < 2 && edges < 60) begin
            tick();
            edges++;
            if (drop) begin mm_req = 1'b0; drop = 1'b0; end
            if (mm_done === 1'b1) begin
                done_edges[nd] = edges;
                nd++;
                if (nd == 1) begin mm_addr = 32'h440; mm_wdata = wb; drop = 1'b1; end
            end
        end
        mm_req = 1'b0;
        checks++; if (done_edges[0] != 9) begin fails++; $display("FAIL b2b_first_done: got %0d want 9", done_edges[0]); end
        checks++; if (done_edges[1] != 18) begin fails++; $display("FAIL b2b_second_done: got %0d want 18", done_edges[1]); end
        for (int k = 0; k < 8; k++) begin
            model_mem[word_of(32'h400) + k] = wa[32*k +: 32];
            model_mem[word_of(32'h440) + k] = wb[32*k +: 32];
        end
        for (int k = 0; k < 16; k++) begin
            w = word_of(32'h400) + k;
            daddr = 32'(w * 4); #1;
            checks++; if (drdata !== model_mem[w]) begin fails++; $display("FAIL b2b_word_%0d: got %h want %h", k, drdata, model_mem[w]); end
        end
    endtask

    task automatic test_random();
        logic [255:0] wd;
        logic [31:0]  a, st_a, d;
        logic [3:0]   be;
        int done_at, sb, base, w, exp_edges;
        logic busy_at;
        for (int it = 0; it < 8; it++) begin
            a = $urandom;
            base = burst_base(a);
            for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
            sb = $urandom_range(0, 8);
            if (sb == 8) sb = -1;
            st_a = ($urandom_range(0, 1) == 1) ? 32'(((base + $urandom_range(0, 7)) % DEPTH) * 4) : $urandom;
            exp_edges = (sb < 0) ? 9 : 10;
            do_burst(1'b1, a, wd, sb, st_a, $urandom, -1, 32'h0, done_at, busy_at);
            checks++; if (done_at != exp_edges) begin fails++; $display("FAIL rnd%0d_wr_done: got %0d want %0d", it, done_at, exp_edges); end
            for (int k = 0; k < 8; k++) begin
                w = (base + k) % DEPTH;
                daddr = 32'(w * 4) | ($urandom & 32'hFFFF_F000); #1;
                checks++; if (drdata !== model_mem[w]) begin fails++; $display("FAIL rnd%0d_word_%0d: got %h want %h", it, k, drdata, model_mem[w]); end
            end
            sb = $urandom_range(0, 8);
            if (sb == 8) sb = -1;
            st_a = 32'(((base + $urandom_range(0, 7)) % DEPTH) * 4);
            exp_edges = (sb < 0) ? 9 : 10;
            do_burst(1'b0, a, 256'h0, sb, st_a, $urandom, -1, 32'h0, done_at, busy_at);
            checks++; if (done_at != exp_edges) begin fails++; $display("FAIL rnd%0d_rd_done: got %0d want %0d", it, done_at, exp_edges); end
            checks++; if (mm_rdata !== model_rdata) begin fails++; $display("FAIL rnd%0d_rdata: got %h want %h", it, mm_rdata, model_rdata); end
            w  = (base + $urandom_range(0, 7)) % DEPTH;
            be = 4'($urandom_range(1, 15));
            d  = $urandom;
            cpu_store(32'(w * 4) | 32'($urandom_range(0, 3)), d, be);
            daddr = 32'(w * 4); #1;
            checks++; if (drdata !== model_mem[w]) begin fails++; $display("FAIL rnd%0d_byte: got %h want %h", it, drdata, model_mem[w]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        daddr = '0; dwdata = '0; dwe = '0;
        mm_req = 1'b0; mm_we = 1'b0; mm_addr = '0; mm_wdata = '0;
        s_daddr = '0; s_dwdata = '0; s_dwe = '0;
        s_mm_req = 1'b0; s_mm_we = 1'b0; s_mm_addr = '0; s_mm_wdata = '0;
        model_rdata = '0;
        test_reset();
        test_wide_write_read();
        test_cpu_stall();
        test_byte_store();
        test_wrap();
        test_ignored_req_and_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
